// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage signed ALU with flags, optional saturation and valid/ready on both sides
module alu_pipe #(
    parameter int N_BITS = 16,
    parameter bit SAT_EN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_BITS-1:0] i_dataA,
    input  logic [N_BITS-1:0] i_dataB,
    input  logic [2:0]        i_op,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [N_BITS-1:0] o_dataC,
    output logic [3:0]        o_flags,
    output logic              o_valid,
    input  logic              i_ready
);
    localparam int SH_W = $clog2(N_BITS);
    localparam int MSB  = N_BITS - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    logic [N_BITS-1:0] s1_a_q, s1_a_d;
    logic [N_BITS-1:0] s1_b_q, s1_b_d;
    logic [2:0]        s1_op_q, s1_op_d;
    logic              s1_valid_q, s1_valid_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic [3:0]        flags_q, flags_d;
    logic              valid_q, valid_d;

    logic              s2_adv;
    logic              accept;
    logic [N_BITS:0]   add_w;
    logic [N_BITS:0]   sub_w;
    logic [SH_W-1:0]   shamt;
    logic [N_BITS-1:0] res;
    logic              ovf;
    logic              carry;

    // S2 frees up when empty or being drained; S1 can then always move forward.
    assign s2_adv  = !valid_q || i_ready;
    assign o_ready = !s1_valid_q || s2_adv;
    assign accept  = i_valid && o_ready;

    assign o_dataC = data_q;
    assign o_flags = flags_q;
    assign o_valid = valid_q;

    always_comb begin
        add_w = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        sub_w = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{N_BITS{1'b0}}, 1'b1};
        shamt = s1_b_q[SH_W-1:0];
        res   = '0;
        ovf   = 1'b0;
        carry = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res   = add_w[MSB:0];
                carry = add_w[N_BITS];
                ovf   = (s1_a_q[MSB] == s1_b_q[MSB]) && (add_w[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                res   = sub_w[MSB:0];
                // No carry-out of A + ~B + 1 means a borrow occurred.
                carry = !sub_w[N_BITS];
                ovf   = (s1_a_q[MSB] != s1_b_q[MSB]) && (sub_w[MSB] != s1_a_q[MSB]);
            end
            OP_AND: res = s1_a_q & s1_b_q;
            OP_OR:  res = s1_a_q | s1_b_q;
            OP_XOR: res = s1_a_q ^ s1_b_q;
            OP_NOR: res = ~(s1_a_q | s1_b_q);
            OP_SRA: res = $signed(s1_a_q) >>> shamt;
            OP_SRL: res = s1_a_q >> shamt;
            default: res = '0;
        endcase
        if (SAT_EN && ovf) begin
            res = s1_a_q[MSB] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
        end
    end

    always_comb begin
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_a_d     = i_dataA;
            s1_b_d     = i_dataB;
            s1_op_d    = i_op;
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        data_d  = data_q;
        flags_d = flags_q;
        valid_d = valid_q;
        if (s2_adv) begin
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d  = res;
                flags_d = {ovf, carry, res[MSB], (res == '0)};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_valid_q <= 1'b0;
            data_q     <= '0;
            flags_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_valid_q <= s1_valid_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined signed ALU. Successor to the combinational add/sub/and/or selector. Adds wider opcode set, status flags, optional saturation and a valid/ready handshake on both sides. Sits between an operand source (switch/register front end or another datapath stage) and any result consumer that may apply backpressure.

## Interface
- N_BITS, 16, operand/result width; power of 2, >= 4
- SAT_EN, 0, 1 = ADD/SUB saturate on signed overflow; 0 = wrap
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_dataA  in  N_BITS  signed operand A
- i_dataB  in  N_BITS  signed operand B; low log2(N_BITS) bits = shift amount for shifts
- i_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SRA (A>>>B), 7 SRL (A>>B)
- i_valid  in  1  upstream operand valid
- o_ready  out  1  ALU can accept operands this cycle
- o_dataC  out  N_BITS  signed result
- o_flags  out  4  {ovf, carry, neg, zero}
- o_valid  out  1  o_dataC/o_flags valid
- i_ready  in  1  downstream accepts result this cycle

## Operation
- Stage 1 (S1): on accept (i_valid & o_ready) register A, B, op; set s1_valid.
- Stage 2 (S2): compute from S1 registers; register result, flags; set o_valid.
- Arithmetic in N_BITS+1 bits. ADD: carry = unsigned carry-out. SUB: A + ~B + 1; carry = borrow = (A <u B).
- ovf (ADD/SUB only): operands' signs compatible and result sign differs. ovf = 0 and carry = 0 for all other ops.
- SAT_EN=1 with ovf=1: result = 0x7FF..F if A non-negative, else 0x800..0. ovf still reported. SAT_EN=0: wrapped result.
- Shifts use B[log2(N_BITS)-1:0]. Upper bits of B are ignored. Shift by 0 passes A through.
- neg = result MSB; zero = (result == 0). Both are computed on the final result, after saturation.
- Flow control:
  - S2 advances when !o_valid | i_ready.
  - S1 advances into S2 when s1_valid & (!o_valid | i_ready).
  - o_ready = !s1_valid | (!o_valid | i_ready) (combinational).
- Stalled stages hold contents unchanged. o_dataC/o_flags remain stable while o_valid & !i_ready.
- Results leave in acceptance order. No drop, no duplication.

## Timing
- Reset (async assert, clears immediately): S1/S2 registers, o_dataC = 0, o_flags = 0, o_valid = 0, s1_valid = 0; o_ready = 1 while in reset and after release.
- Latency: operand accepted at edge k → o_valid high after edge k+1, with no stall.
- Throughput: 1 op/cycle with i_ready held high.
- Capacity: 2 ops in flight. With i_ready low, o_ready drops after the second accept.
- Simultaneous pop (o_valid & i_ready) and push in the same cycle: both occur; the pipeline shifts with no bubble.
- Reset mid-operation: in-flight ops are discarded. The first result after release is the first op accepted after release.
- i_valid may drop without a transfer; no upstream data hold requirement beyond the accept cycle.

## Test plan
- ADD 0x7FFF + 0x0001, SAT_EN=0 → o_dataC 0x8000, flags ovf=1 carry=0 neg=1 zero=0. SAT_EN=1 → 0x7FFF, ovf=1 neg=0.
- SUB 0x0003 − 0x0005 → 0xFFFE, carry(borrow)=1 neg=1 ovf=0. SUB 0x8000 − 0x0001 with SAT_EN=1 → 0x8000, ovf=1.
- SRA 0x8000 by B=0x0014 (uses 4) → 0xF800. SRL same → 0x0800. XOR 0x5A5A^0x5A5A → 0x0000 zero=1. NOR 0x0000,0x0000 → 0xFFFF.
- Back-to-back 8 random ops with i_ready=1 → 8 results on consecutive cycles, each 2 cycles after its accept, matching a reference model.
- Backpressure: i_ready=0, offer 3 ops → 2 accepted, o_ready=0, o_dataC stable. Raise i_ready → results drain in order, third op accepted same cycle as first pop.
- Assert i_rst_n=0 with 2 ops in flight → o_valid=0, o_dataC=0, o_flags=0 immediately. After release, o_ready=1 and no stale result appears.
